div_sqrt_round_pack_mvp: RTL

//  Back-end of the div/sqrt datapath. Takes the unrounded result of the iteration

---
 rtl/div_sqrt_round_pack_mvp.sv | 218 +++++++++++++++++++++
 1 files changed

// File: rtl/div_sqrt_round_pack_mvp.sv
// Rounding and packing back-end of the div/sqrt datapath: stage 1 denormalizes and rounds,
// stage 2 handles overflow and special cases, packs the IEEE encoding and raises flags.
module div_sqrt_round_pack_mvp #(
    parameter bit NANBOX = 1'b1
) (
    input  logic        Clk_CI,
    input  logic        Rst_RBI,
    input  logic        Kill_SI,
    input  logic        In_valid_SI,
    output logic        In_ready_SO,
    input  logic [1:0]  Format_sel_SI,
    input  logic [2:0]  RM_SI,
    input  logic        Sign_SI,
    input  logic [12:0] Exp_DI,
    input  logic [55:0] Mant_DI,
    input  logic        Sticky_SI,
    input  logic [3:0]  Spec_SI,
    output logic        Out_valid_SO,
    input  logic        Out_ready_SI,
    output logic [63:0] Result_DO,
    output logic [4:0]  Flags_SO
);

    localparam logic [1:0] FMT_FP32    = 2'b00;
    localparam logic [1:0] FMT_FP64    = 2'b01;
    localparam logic [1:0] FMT_FP16    = 2'b10;
    localparam logic [1:0] FMT_FP16ALT = 2'b11;

    localparam logic [2:0] RM_TRUNC       = 3'd1;
    localparam logic [2:0] RM_PLUSINF     = 3'd2;
    localparam logic [2:0] RM_MINUSINF    = 3'd3;
    localparam logic [2:0] RM_NEAREST_MAX = 3'd4;

    // Valid/ready: a beat moves on a rising edge when valid & ready are both high; a
    // stage loads whenever it is empty or the stage after it is draining this edge.
    logic s1_v, s2_v, s2_en;

    assign s2_en        = ~s2_v | Out_ready_SI;
    assign In_ready_SO  = ~s1_v | s2_en;
    assign Out_valid_SO = s2_v;

    // ---------------- stage 1: denormalize and round ----------------
    logic [13:0] shamt_full;
    logic [5:0]  shamt, shamt_max;
    logic [55:0] mant_sh, lost_mask;
    logic        tiny_c, lost_c, rnd_c, stk_c, inc_c, carry_c, hid_c;
    logic [52:0] kept_c;
    logic [53:0] rounded_c;
    logic [51:0] frac_c;
    logic [12:0] exp_c;

    always_comb begin
        shamt_max = 6'd25;
        unique case (Format_sel_SI)
            FMT_FP32:    shamt_max = 6'd25;
            FMT_FP64:    shamt_max = 6'd54;
            FMT_FP16:    shamt_max = 6'd12;
            FMT_FP16ALT: shamt_max = 6'd9;
        endcase

        tiny_c     = Exp_DI[12] | (Exp_DI == 13'd0);
        shamt_full = 14'd1 - {Exp_DI[12], Exp_DI};
        shamt      = 6'd0;
        if (tiny_c)
            shamt = (shamt_full > {8'd0, shamt_max}) ? shamt_max : shamt_full[5:0];
        mant_sh   = Mant_DI >> shamt;
        lost_mask = ~({56{1'b1}} << shamt);
        lost_c    = |(Mant_DI & lost_mask);

        kept_c = '0;
        rnd_c  = 1'b0;
        stk_c  = 1'b0;
        unique case (Format_sel_SI)
            FMT_FP32:    begin kept_c = {29'd0, mant_sh[55:32]}; rnd_c = mant_sh[31]; stk_c = |mant_sh[30:0]; end
            FMT_FP64:    begin kept_c = mant_sh[55:3];           rnd_c = mant_sh[2];  stk_c = |mant_sh[1:0];  end
            FMT_FP16:    begin kept_c = {42'd0, mant_sh[55:45]}; rnd_c = mant_sh[44]; stk_c = |mant_sh[43:0]; end
            FMT_FP16ALT: begin kept_c = {45'd0, mant_sh[55:48]}; rnd_c = mant_sh[47]; stk_c = |mant_sh[46:0]; end
        endcase
        stk_c = stk_c | Sticky_SI | lost_c;

        case (RM_SI)
            RM_TRUNC:       inc_c = 1'b0;
            RM_PLUSINF:     inc_c = (rnd_c | stk_c) & ~Sign_SI;
            RM_MINUSINF:    inc_c = (rnd_c | stk_c) & Sign_SI;
            RM_NEAREST_MAX: inc_c = rnd_c;
            default:        inc_c = rnd_c & (stk_c | kept_c[0]);
        endcase
        rounded_c = {1'b0, kept_c} + {53'd0, inc_c};

        // carry_c: normal mantissa overflowed to 2.0; hid_c: subnormal reached 1.0
        carry_c = 1'b0;
        hid_c   = 1'b0;
        frac_c  = '0;
        unique case (Format_sel_SI)
            FMT_FP32:    begin carry_c = rounded_c[24]; hid_c = rounded_c[23]; frac_c = {29'd0, rounded_c[22:0]}; end
            FMT_FP64:    begin carry_c = rounded_c[53]; hid_c = rounded_c[52]; frac_c = rounded_c[51:0];          end
            FMT_FP16:    begin carry_c = rounded_c[11]; hid_c = rounded_c[10]; frac_c = {42'd0, rounded_c[9:0]};  end
            FMT_FP16ALT: begin carry_c = rounded_c[8];  hid_c = rounded_c[7];  frac_c = {45'd0, rounded_c[6:0]};  end
        endcase
        exp_c = tiny_c ? {12'd0, hid_c} : Exp_DI + {12'd0, carry_c};
    end

    logic [1:0]  s1_fmt;
    logic [2:0]  s1_rm;
    logic        s1_sign, s1_nx, s1_tiny;
    logic [12:0] s1_exp;
    logic [51:0] s1_frac;
    logic [3:0]  s1_spec;

    // ---------------- stage 2: overflow, specials, pack ----------------
    logic [12:0] e_inf;
    logic [63:0] box, num, inf, maxf, qnan, zero, pk_res;
    logic [4:0]  pk_flags;
    logic        to_inf;

    always_comb begin
        e_inf = 13'd255;
        box   = '0;
        num   = '0;
        inf   = '0;
        maxf  = '0;
        qnan  = '0;
        zero  = '0;
        unique case (s1_fmt)
            FMT_FP32: begin
                e_inf = 13'd255;  box = 64'hFFFF_FFFF_0000_0000; qnan = 64'h0000_0000_7FC0_0000;
                num  = {32'd0, s1_sign, s1_exp[7:0], s1_frac[22:0]};
                inf  = {32'd0, s1_sign, 8'hFF, 23'd0};
                maxf = {32'd0, s1_sign, 8'hFE, {23{1'b1}}};
                zero = {32'd0, s1_sign, 31'd0};
            end
            FMT_FP64: begin
                e_inf = 13'd2047; box = 64'd0; qnan = 64'h7FF8_0000_0000_0000;
                num  = {s1_sign, s1_exp[10:0], s1_frac};
                inf  = {s1_sign, 11'h7FF, 52'd0};
                maxf = {s1_sign, 11'h7FE, {52{1'b1}}};
                zero = {s1_sign, 63'd0};
            end
            FMT_FP16: begin
                e_inf = 13'd31;   box = 64'hFFFF_FFFF_FFFF_0000; qnan = 64'h0000_0000_0000_7E00;
                num  = {48'd0, s1_sign, s1_exp[4:0], s1_frac[9:0]};
                inf  = {48'd0, s1_sign, 5'h1F, 10'd0};
                maxf = {48'd0, s1_sign, 5'h1E, {10{1'b1}}};
                zero = {48'd0, s1_sign, 15'd0};
            end
            FMT_FP16ALT: begin
                e_inf = 13'd255;  box = 64'hFFFF_FFFF_FFFF_0000; qnan = 64'h0000_0000_0000_7FC0;
                num  = {48'd0, s1_sign, s1_exp[7:0], s1_frac[6:0]};
                inf  = {48'd0, s1_sign, 8'hFF, 7'd0};
                maxf = {48'd0, s1_sign, 8'hFE, {7{1'b1}}};
                zero = {48'd0, s1_sign, 15'd0};
            end
        endcase

        to_inf = ~((s1_rm == RM_TRUNC) || (s1_rm == RM_PLUSINF && s1_sign) ||
                   (s1_rm == RM_MINUSINF && !s1_sign));

        pk_res   = num;
        pk_flags = {3'b000, s1_tiny & s1_nx, s1_nx};
        if (s1_spec[3]) begin
            pk_res   = qnan;
            pk_flags = 5'b10000;
        end else if (s1_spec[2]) begin
            pk_res   = inf;
            pk_flags = 5'b01000;
        end else if (s1_spec[1]) begin
            pk_res   = inf;
            pk_flags = 5'b00000;
        end else if (s1_spec[0]) begin
            pk_res   = zero;
            pk_flags = 5'b00000;
        end else if (s1_exp >= e_inf) begin
            pk_res   = to_inf ? inf : maxf;
            pk_flags = 5'b00101;
        end
        pk_res = pk_res | (NANBOX ? box : 64'd0);
    end

    always_ff @(posedge Clk_CI or negedge Rst_RBI) begin
        if (!Rst_RBI) begin
            s1_v      <= 1'b0;
            s2_v      <= 1'b0;
            s1_fmt    <= '0;
            s1_rm     <= '0;
            s1_sign   <= 1'b0;
            s1_nx     <= 1'b0;
            s1_tiny   <= 1'b0;
            s1_exp    <= '0;
            s1_frac   <= '0;
            s1_spec   <= '0;
            Result_DO <= '0;
            Flags_SO  <= '0;
        end else begin
            if (Kill_SI) begin
                s1_v <= 1'b0;
                s2_v <= 1'b0;
            end else begin
                if (s2_en)       s2_v <= s1_v;
                if (In_ready_SO) s1_v <= In_valid_SI;
            end
            if (In_ready_SO && In_valid_SI) begin
                s1_fmt  <= Format_sel_SI;
                s1_rm   <= RM_SI;
                s1_sign <= Sign_SI;
                s1_nx   <= rnd_c | stk_c;
                s1_tiny <= tiny_c;
                s1_exp  <= exp_c;
                s1_frac <= frac_c;
                s1_spec <= Spec_SI;
            end
            if (s2_en && s1_v) begin
                Result_DO <= pk_res;
                Flags_SO  <= pk_flags;
            end
        end
    end

endmodule
